// File: rtl/izhikevich_scheduler.sv
// rtl/izhikevich_scheduler.sv - time-multiplexed Izhikevich neuron state sweeper
module izhikevich_scheduler #(
    parameter int N           = 32,
    parameter int Q           = 16,
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     v_init,
    input  logic [N-1:0]     w_init,
    input  logic [N-1:0]     v_th,
    input  logic [N-1:0]     c,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] cur_idx,
    input  logic [N-1:0]     i_cur,
    output logic [N-1:0]     dp_voltage,
    output logic [N-1:0]     dp_w,
    output logic [N-1:0]     dp_i,
    input  logic [N-1:0]     dp_new_voltage,
    input  logic [N-1:0]     dp_new_w,
    input  logic [N-1:0]     dp_w_at_th,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [N-1:0]     load_v,
    input  logic [N-1:0]     load_w,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_idx,
    output logic [31:0]      step_count
);

    // Fractional bits only matter to the external datapath; sanity-check the set.
    if (Q >= N || (1 << IDX_W) < NUM_NEURONS) begin : g_param_check
        $error("izhikevich_scheduler: inconsistent Q/N or IDX_W/NUM_NEURONS");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    localparam logic [IDX_W:0]   NUM_N    = (IDX_W + 1)'(NUM_NEURONS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [N-1:0]     v_mem [NUM_NEURONS];
    logic [N-1:0]     w_mem [NUM_NEURONS];
    logic [31:0]      step_cnt_q;
    logic             above_th;
    logic             load_ok;

    assign above_th   = $signed(v_mem[cur_idx]) > $signed(v_th);
    assign load_ok    = {1'b0, load_idx} < NUM_N;
    assign step_count = step_cnt_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one neuron per SWEEP cycle, DONE after the last index
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SWEEP;
            SWEEP:   if (cur_idx == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: status flags and the operands handed to the shared datapath
    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        dp_voltage = v_mem[cur_idx];
        dp_w       = w_mem[cur_idx];
        dp_i       = i_cur;
    end

    // Sequencing registers: neuron index, sweep counter, registered spike event
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_idx     <= '0;
            step_cnt_q  <= '0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
        end else begin
            spike_valid <= (state_q == SWEEP) && above_th;
            if (state_q == SWEEP) begin
                spike_idx <= cur_idx;
                cur_idx   <= (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
            end else begin
                cur_idx <= '0;
            end
            if (state_q == DONE) begin
                step_cnt_q <= step_cnt_q + 32'd1;
            end
        end
    end

    // Neuron state: reset fill, sweep update (spike or integrate), idle preload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                v_mem[k] <= v_init;
                w_mem[k] <= w_init;
            end
        end else if (state_q == SWEEP) begin
            if (above_th) begin
                v_mem[cur_idx] <= c;
                w_mem[cur_idx] <= dp_w_at_th;
            end else begin
                v_mem[cur_idx] <= dp_new_voltage;
                w_mem[cur_idx] <= dp_new_w;
            end
        end else if (state_q == IDLE && load_en && load_ok) begin
            v_mem[load_idx] <= load_v;
            w_mem[load_idx] <= load_w;
        end
    end

endmodule

// File: tb/tb_izhikevich_scheduler.sv
// tb/tb_izhikevich_scheduler.sv - directed self-checking bench for izhikevich_scheduler
module tb_izhikevich_scheduler;

    localparam int N  = 32;
    localparam int NN = 8;

    localparam logic [31:0] V_INIT = 32'hFFBF_0000;   // -65.0
    localparam logic [31:0] W_INIT = 32'hFFF2_0000;   // -14.0
    localparam logic [31:0] V_TH   = 32'h001E_0000;   //  30.0
    localparam logic [31:0] C_V    = 32'hFFBF_0000;   // -65.0
    localparam logic [31:0] V_STEP = 32'h0001_0000;   // model dv = +1.0
    localparam logic [31:0] W_STEP = 32'h0000_1000;   // model dw
    localparam logic [31:0] D_W    = 32'h0008_0000;   // model d  = +8.0

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  v_init, w_init, v_th, c;
    logic          start;
    logic          busy, done;
    logic [2:0]    cur_idx;
    logic [N-1:0]  i_cur;
    logic [N-1:0]  dp_voltage, dp_w, dp_i;
    logic [N-1:0]  dp_new_voltage, dp_new_w, dp_w_at_th;
    logic          load_en;
    logic [2:0]    load_idx;
    logic [N-1:0]  load_v, load_w;
    logic          spike_valid;
    logic [2:0]    spike_idx;
    logic [31:0]   step_count;

    int total = 0;
    int bad   = 0;

    // Results of the most recent do_sweep
    logic [N-1:0] cap_v [NN];
    logic [N-1:0] cap_w [NN];
    int           spk_cyc [NN];
    logic [7:0]   spk_mask;
    int           spk_cnt, busy_cnt, done_cnt, done_cyc;
    logic         idx_ok;

    always #5 clk = ~clk;

    // Simple stand-in datapath: v+1.0+i, w+W_STEP, w+d
    assign dp_new_voltage = dp_voltage + dp_i + V_STEP;
    assign dp_new_w       = dp_w + W_STEP;
    assign dp_w_at_th     = dp_w + D_W;

    izhikevich_scheduler #(.N(N), .Q(16), .NUM_NEURONS(NN), .IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .v_init(v_init), .w_init(w_init),
        .v_th(v_th), .c(c), .start(start), .busy(busy), .done(done),
        .cur_idx(cur_idx), .i_cur(i_cur), .dp_voltage(dp_voltage), .dp_w(dp_w),
        .dp_i(dp_i), .dp_new_voltage(dp_new_voltage), .dp_new_w(dp_new_w),
        .dp_w_at_th(dp_w_at_th), .load_en(load_en), .load_idx(load_idx),
        .load_v(load_v), .load_w(load_w), .spike_valid(spike_valid),
        .spike_idx(spike_idx), .step_count(step_count)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [2:0] idx, input logic [31:0] v, input logic [31:0] w);
        @(negedge clk);
        load_en = 1'b1; load_idx = idx; load_v = v; load_w = w;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // mode 0: plain; 1: start+load pulsed mid-sweep; 2: reset at cur_idx 4; 3: load with start
    task automatic do_sweep(input int mode);
        spk_mask = '0; spk_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1; idx_ok = 1'b1;
        for (int k = 0; k < NN; k++) begin
            cap_v[k] = 'x; cap_w[k] = 'x; spk_cyc[k] = -1;
        end
        @(negedge clk);
        start = 1'b1;
        if (mode == 3) load_en = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            start = 1'b0; load_en = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (spike_valid) begin
                spk_cnt++; spk_mask[spike_idx] = 1'b1; spk_cyc[spike_idx] = cyc;
            end
            if (busy && !done && cyc <= NN) begin
                if (cur_idx !== 3'(cyc - 1)) idx_ok = 1'b0;
                cap_v[cur_idx] = dp_voltage;
                cap_w[cur_idx] = dp_w;
            end
            if (mode == 1 && cyc >= 2 && cyc <= 5) begin
                start = 1'b1; load_en = 1'b1;
            end
            if (mode == 2 && cyc == 5) rst_n = 1'b0;
            if (mode == 2 && cyc == 6) rst_n = 1'b1;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        if (busy !== 1'b0 || done !== 1'b0 || spike_valid !== 1'b0) begin
            bad++; $display("FAIL reset_flags busy=%b done=%b spk=%b want 0 0 0", busy, done, spike_valid);
        end
        total++;
        if (cur_idx !== 3'd0 || spike_idx !== 3'd0 || step_count !== 32'd0) begin
            bad++; $display("FAIL reset_regs idx=%0d sidx=%0d steps=%0d want 0 0 0", cur_idx, spike_idx, step_count);
        end
        total++;
        if (dp_voltage !== V_INIT || dp_w !== W_INIT) begin
            bad++; $display("FAIL reset_dp v=%h w=%h want %h %h", dp_voltage, dp_w, V_INIT, W_INIT);
        end
        total++;
    endtask

    task automatic test_basic_sweep();
        do_sweep(0);
        if (busy_cnt !== 9 || done_cyc !== 9 || done_cnt !== 1) begin
            bad++; $display("FAIL basic_timing busy=%0d done_at=%0d dones=%0d want 9 9 1", busy_cnt, done_cyc, done_cnt);
        end
        total++;
        if (idx_ok !== 1'b1) begin
            bad++; $display("FAIL basic_idx_seq got out-of-order cur_idx want 0..7");
        end
        total++;
        if (step_count !== 32'd1 || spk_cnt !== 0) begin
            bad++; $display("FAIL basic_count steps=%0d spikes=%0d want 1 0", step_count, spk_cnt);
        end
        total++;
        do_sweep(0);
        if (cap_v[7] !== 32'hFFC0_0000 || cap_w[7] !== 32'hFFF2_1000) begin
            bad++; $display("FAIL basic_update v7=%h w7=%h want ffc00000 fff21000", cap_v[7], cap_w[7]);
        end
        total++;
    endtask

    task automatic test_spike();
        apply_reset();
        load(3'd3, 32'h0023_0000, 32'h0005_0000);
        do_sweep(0);
        if (spk_mask !== 8'b0000_1000 || spk_cnt !== 1 || spk_cyc[3] !== 5) begin
            bad++; $display("FAIL spike_event mask=%b cnt=%0d at=%0d want 00001000 1 5", spk_mask, spk_cnt, spk_cyc[3]);
        end
        total++;
        do_sweep(0);
        if (cap_v[3] !== C_V || cap_w[3] !== 32'h000D_0000) begin
            bad++; $display("FAIL spike_reset v3=%h w3=%h want %h 000d0000", cap_v[3], cap_w[3], C_V);
        end
        total++;
        if (cap_v[2] !== 32'hFFC0_0000 || spk_cnt !== 0) begin
            bad++; $display("FAIL spike_other v2=%h spikes=%0d want ffc00000 0", cap_v[2], spk_cnt);
        end
        total++;
    endtask

    task automatic test_threshold_equal();
        apply_reset();
        load(3'd5, V_TH, 32'h0000_0000);
        do_sweep(0);
        if (spk_cnt !== 0) begin
            bad++; $display("FAIL equal_no_spike spikes=%0d want 0", spk_cnt);
        end
        total++;
        do_sweep(0);
        if (cap_v[5] !== 32'h001F_0000 || cap_w[5] !== 32'h0000_1000) begin
            bad++; $display("FAIL equal_update v5=%h w5=%h want 001f0000 00001000", cap_v[5], cap_w[5]);
        end
        total++;
    endtask

    task automatic test_consecutive_spikes();
        apply_reset();
        load(3'd2, 32'h0023_0000, 32'h0);
        load(3'd3, 32'h0024_0000, 32'h0);
        do_sweep(0);
        if (spk_mask !== 8'b0000_1100 || spk_cyc[2] !== 4 || spk_cyc[3] !== 5) begin
            bad++; $display("FAIL consec_spikes mask=%b at2=%0d at3=%0d want 00001100 4 5", spk_mask, spk_cyc[2], spk_cyc[3]);
        end
        total++;
    endtask

    task automatic test_busy_ignore();
        apply_reset();
        load_idx = 3'd6; load_v = 32'h0040_0000; load_w = 32'h0011_0000;
        do_sweep(1);
        if (busy_cnt !== 9 || done_cnt !== 1 || step_count !== 32'd1) begin
            bad++; $display("FAIL busy_ignore_timing busy=%0d dones=%0d steps=%0d want 9 1 1", busy_cnt, done_cnt, step_count);
        end
        total++;
        do_sweep(0);
        if (cap_v[6] !== 32'hFFC0_0000 || cap_w[6] !== 32'hFFF2_1000) begin
            bad++; $display("FAIL busy_ignore_load v6=%h w6=%h want ffc00000 fff21000", cap_v[6], cap_w[6]);
        end
        total++;
    endtask

    task automatic test_load_with_start();
        apply_reset();
        load_idx = 3'd0; load_v = 32'h0023_0000; load_w = 32'h0001_0000;
        do_sweep(3);
        if (spk_mask !== 8'b0000_0001 || spk_cyc[0] !== 2) begin
            bad++; $display("FAIL load_start_spike mask=%b at=%0d want 00000001 2", spk_mask, spk_cyc[0]);
        end
        total++;
        if (cap_v[0] !== 32'h0023_0000 || cap_w[0] !== 32'h0001_0000) begin
            bad++; $display("FAIL load_start_seen v0=%h w0=%h want 00230000 00010000", cap_v[0], cap_w[0]);
        end
        total++;
    endtask

    task automatic test_reset_mid_sweep();
        apply_reset();
        do_sweep(0);
        do_sweep(2);
        if (done_cnt !== 0 || busy !== 1'b0 || step_count !== 32'd0) begin
            bad++; $display("FAIL midreset_state dones=%0d busy=%b steps=%0d want 0 0 0", done_cnt, busy, step_count);
        end
        total++;
        do_sweep(0);
        if (cap_v[0] !== V_INIT || cap_v[3] !== V_INIT || cap_v[7] !== V_INIT || cap_w[2] !== W_INIT) begin
            bad++; $display("FAIL midreset_values v0=%h v3=%h v7=%h w2=%h want %h/%h", cap_v[0], cap_v[3], cap_v[7], cap_w[2], V_INIT, W_INIT);
        end
        total++;
    endtask

    task automatic test_back_to_back();
        int d1, d2, idle_gap, base;
        apply_reset();
        base = 32'(step_count);
        d1 = -1; d2 = -1; idle_gap = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (done && d1 < 0) d1 = cyc;
            else if (done && d2 < 0) begin d2 = cyc; start = 1'b0; end
            if (d1 >= 0 && d2 < 0 && !busy) idle_gap++;
        end
        if (d1 !== 9 || d2 !== 19 || idle_gap !== 1) begin
            bad++; $display("FAIL b2b_timing done1=%0d done2=%0d gap=%0d want 9 19 1", d1, d2, idle_gap);
        end
        total++;
        if (step_count !== 32'(base + 2)) begin
            bad++; $display("FAIL b2b_count steps=%0d want %0d", step_count, base + 2);
        end
        total++;
    endtask

    task automatic test_step_wrap();
        @(negedge clk);
        force dut.step_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.step_cnt_q;
        do_sweep(0);
        if (step_count !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL wrap_pre steps=%h want ffffffff", step_count);
        end
        total++;
        do_sweep(0);
        if (step_count !== 32'd0) begin
            bad++; $display("FAIL wrap_zero steps=%h want 00000000", step_count);
        end
        total++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; load_en = 1'b0; load_idx = '0;
        load_v = '0; load_w = '0; i_cur = '0;
        v_init = V_INIT; w_init = W_INIT; v_th = V_TH; c = C_V;
        test_reset();
        test_basic_sweep();
        test_spike();
        test_threshold_equal();
        test_consecutive_spikes();
        test_busy_ignore();
        test_load_with_start();
        test_reset_mid_sweep();
        test_back_to_back();
        test_step_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/izhikevich_scheduler.md
IZHIKEVICH_SCHEDULER -- requirements
Module: izhikevich_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning fixed-point word width.
REQ-002 The block SHALL have parameter Q, default 16, meaning fractional bits (Q16.16 signed).
REQ-003 The block SHALL have parameter NUM_NEURONS, default 8, meaning neurons time-multiplexed onto one datapath.
REQ-004 The block SHALL have parameter IDX_W, default 3, meaning index width, equal to clog2(NUM_NEURONS).
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic on posedge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, meaning synchronous, active-low reset.
REQ-007 The block SHALL have ports v_init and w_init, input, N bits each, meaning reset values for every neuron.
REQ-008 The block SHALL have ports v_th and c, input, N bits each, meaning spike threshold and post-spike voltage.
REQ-009 The block SHALL have port start, input, 1 bit, meaning a request for one timestep sweep.
REQ-010 The block SHALL have port busy, output, 1 bit, meaning a sweep is in progress.
REQ-011 The block SHALL have port done, output, 1 bit, meaning a one-cycle pulse at the end of a sweep.
REQ-012 The block SHALL have port cur_idx, output, IDX_W bits, meaning the neuron being processed.
REQ-013 The block SHALL have port i_cur, input, N bits, meaning external input current for cur_idx, same cycle.
REQ-014 The block SHALL have ports dp_voltage, dp_w and dp_i, output, N bits each, meaning operands to the shared combinational update datapath.
REQ-015 The block SHALL have ports dp_new_voltage, dp_new_w and dp_w_at_th, input, N bits each, meaning datapath results (v+dv, w+dw, w+d).
REQ-016 The block SHALL have ports load_en (1 bit), load_idx (IDX_W bits), load_v (N bits) and load_w (N bits), all inputs, meaning a state preload write.
REQ-017 The block SHALL have ports spike_valid (1 bit) and spike_idx (IDX_W bits), outputs, meaning a spike event.
REQ-018 The block SHALL have port step_count, output, 32 bits, meaning the number of completed sweeps.

Function
REQ-019 The block SHALL hold per-neuron state v[NUM_NEURONS] and w[NUM_NEURONS] in internal registers.
REQ-020 The FSM SHALL have states IDLE, SWEEP and DONE.
REQ-021 In IDLE with start=1, the FSM SHALL move to SWEEP next cycle with cur_idx=0.
REQ-022 In SWEEP, the block SHALL process one neuron per cycle: dp_voltage=v[cur_idx], dp_w=w[cur_idx], dp_i=i_cur, all combinational.
REQ-023 If $signed(v[cur_idx]) > $signed(v_th), the block SHALL write v[cur_idx]<=c and w[cur_idx]<=dp_w_at_th, and pulse spike_valid=1 with spike_idx=cur_idx in the following cycle.
REQ-024 Otherwise, the block SHALL write v[cur_idx]<=dp_new_voltage and w[cur_idx]<=dp_new_w, with no spike.
REQ-025 Threshold equality SHALL NOT spike (strict greater-than, signed).
REQ-026 cur_idx SHALL increment each SWEEP cycle; at NUM_NEURONS-1 the FSM SHALL go to DONE, so a sweep takes exactly NUM_NEURONS cycles.
REQ-027 In DONE, the block SHALL assert done=1 for one cycle, increment step_count (wrapping from 0xFFFFFFFF to 0), reset cur_idx to 0, and return to IDLE.
REQ-028 busy SHALL be 1 in SWEEP and DONE and 0 in IDLE, so start-to-done latency is NUM_NEURONS+1 cycles.
REQ-029 start SHALL be ignored while busy; a start held high in IDLE SHALL begin a new sweep, back-to-back with a 1-cycle IDLE gap.
REQ-030 load_en SHALL write v[load_idx]<=load_v and w[load_idx]<=load_w only in IDLE.
REQ-031 load_en SHALL be ignored while busy.
REQ-032 If load_en and start are both high in the same IDLE cycle, the load SHALL take effect and the sweep SHALL start next cycle, seeing the loaded values.
REQ-033 load_idx >= NUM_NEURONS SHALL be ignored.
REQ-034 In IDLE, dp_* outputs SHALL present neuron cur_idx (0) with state unchanged.
REQ-035 The block SHALL never use the datapath results outside SWEEP.
REQ-036 spike_valid SHALL be registered and last exactly one cycle per spike; spikes of consecutive neurons SHALL appear on consecutive cycles.

Reset
REQ-037 With rst_n=0 at posedge, all v[k] SHALL become v_init and all w[k] SHALL become w_init.
REQ-038 With rst_n=0 at posedge, state SHALL become IDLE, with cur_idx=0, busy=0, done=0, spike_valid=0, spike_idx=0 and step_count=0.
REQ-039 Reset asserted mid-sweep SHALL abort the sweep immediately, produce no done pulse, and leave no partial writes beyond the reset values.
REQ-040 Reset SHALL have priority over start and load_en.

Verification
REQ-041 Reset then start with NUM_NEURONS=8 -> busy high for 9 cycles, done pulse at cycle 9 after start, step_count=1, cur_idx sequence 0..7.
REQ-042 v_init=0xFFBF0000 (-65.0), v_th=0x001E0000 (30.0), load neuron 3 with v=0x00230000 (35.0), then start -> spike_valid with spike_idx=3 only; v[3]=c=0xFFBF0000; w[3]=old w+d.
REQ-043 Load neuron 5 with v=0x001E0000 (equal to threshold) -> no spike; v[5]=dp_new_voltage.
REQ-044 Assert start and load_en during SWEEP -> no effect, done still after 9 cycles, loaded neuron unchanged by the load.
REQ-045 Deassert rst_n at cur_idx=4 -> next cycle IDLE, no done, all v=v_init, step_count=0.
REQ-046 Preload step_count near wrap by running 2^32-1 sweeps (or force in the bench), then one more sweep -> step_count wraps to 0.
